// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
// A read strobed in one cycle returns its word on imem_data in the next cycle.
interface instruction_fetch_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] imem_address;
  logic                imem_read;
  logic [15:0]         imem_data;

  modport master (output imem_address, output imem_read, input imem_data);
  modport slave  (input imem_address, input imem_read, output imem_data);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: prefetches 16-bit words into a small FIFO and presents 16/32-bit instructions.
// Optional macro AAP_FETCH_ILLEGAL_CHECK_EN builds the 32-bit second-word legality check.
module instruction_fetch #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  BUFFER_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  instruction_fetch_if.master  imem,
  input  logic                 i_branch_valid,
  input  logic [PC_WIDTH-1:0]  i_branch_target,
  input  logic                 i_decode_stall,
  output logic                 o_fetchvalid,
  output logic [31:0]          o_fetchoutput,
  output logic                 o_fetchlong,
  output logic [PC_WIDTH-1:0]  o_fetchpc,
  output logic                 o_fetchillegal
);
  localparam int            CW      = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);
  localparam logic [CW-1:0] C_DEPTH = CW'(BUFFER_DEPTH);

  // Entry 0 is always the FIFO head; pops shift the buffer down.
  logic [15:0]         r_word [BUFFER_DEPTH];
  logic [PC_WIDTH-1:0] r_tag  [BUFFER_DEPTH];
  logic [CW-1:0]       r_count;
  logic                r_inflight;
  logic [PC_WIDTH-1:0] r_if_pc;
  logic [PC_WIDTH-1:0] r_pc;

  logic                w_head_long;
  logic                w_valid;
  logic                w_issue;
  logic                w_push;
  logic                w_xfer;
  logic [CW-1:0]       w_occ;
  logic [CW-1:0]       w_pop;
  logic [CW-1:0]       w_keep;

  assign w_head_long = r_word[0][15];
  assign w_occ       = r_count + CW'(r_inflight);
  assign w_issue     = i_rst_n & ~i_branch_valid & (w_occ < C_DEPTH);
  assign w_push      = r_inflight & ~i_branch_valid;
  assign w_valid     = i_rst_n & ~i_branch_valid &
                       (w_head_long ? (r_count >= C_TWO) : (r_count >= C_ONE));
  assign w_xfer      = w_valid & ~i_decode_stall;
  assign w_pop       = !w_xfer ? '0 : (w_head_long ? C_TWO : C_ONE);
  assign w_keep      = r_count - w_pop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_if_pc    <= RESET_PC;
      r_pc       <= RESET_PC;
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        r_word[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (i_branch_valid) begin
      // Redirect flushes buffered words and drops the response still in flight.
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_pc       <= i_branch_target;
    end else begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        if (w_pop == C_TWO) begin
          r_word[i] <= r_word[(i + 2) % BUFFER_DEPTH];
          r_tag[i]  <= r_tag[(i + 2) % BUFFER_DEPTH];
        end else if (w_pop == C_ONE) begin
          r_word[i] <= r_word[(i + 1) % BUFFER_DEPTH];
          r_tag[i]  <= r_tag[(i + 1) % BUFFER_DEPTH];
        end
        // Incoming word lands just above whatever survives this cycle's pop.
        if (w_push && (w_keep == CW'(i))) begin
          r_word[i] <= imem.imem_data;
          r_tag[i]  <= r_if_pc;
        end
      end
      r_count    <= w_keep + CW'(w_push);
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_pc <= r_pc;
        r_pc    <= r_pc + PC_WIDTH'(1);
      end
    end
  end

  assign imem.imem_read    = w_issue;
  assign imem.imem_address = r_pc;

  assign o_fetchvalid  = w_valid;
  assign o_fetchlong   = w_valid & w_head_long;
  assign o_fetchoutput = !w_valid ? 32'h0000_0000 :
                         (w_head_long ? {r_word[1], r_word[0]} : {16'h0000, r_word[0]});
  // With an empty buffer, report the address of the next word that will arrive.
  assign o_fetchpc     = (r_count != '0) ? r_tag[0] : (r_inflight ? r_if_pc : r_pc);

`ifdef AAP_FETCH_ILLEGAL_CHECK_EN
  assign o_fetchillegal = w_valid & w_head_long & ~r_word[1][15];
`else
  assign o_fetchillegal = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, meaning the width of the instruction word address.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the word address fetched first after reset.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4, meaning the number of 16-bit word entries in the fetch buffer.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 imem_address  output  PC_WIDTH  instruction memory word address.
REQ-007 imem_read  output  1  read strobe; data returns exactly one cycle later.
REQ-008 imem_data  input  16  word read by the previous cycle's imem_read.
REQ-009 branch_valid  input  1  redirect request.
REQ-010 branch_target  input  PC_WIDTH  redirect word address.
REQ-011 decode_stall  input  1  decoder cannot accept this cycle.
REQ-012 fetchvalid  output  1  fetchoutput holds a complete instruction.
REQ-013 fetchoutput  output  32  {second word, first word} for 32-bit; {16'h0000, first word} for 16-bit.
REQ-014 fetchlong  output  1  instruction is 32-bit (first word bit 15 = 1).
REQ-015 fetchpc  output  PC_WIDTH  word address of the instruction's first word.
REQ-016 fetchillegal  output  1  32-bit instruction whose second word has bit 15 = 0.

Function
REQ-017 SHALL hold words in a BUFFER_DEPTH-entry FIFO, each entry tagged with its word address.
REQ-018 SHALL assert imem_read with imem_address = fetch pointer when (occupancy + reads in flight) < BUFFER_DEPTH and branch_valid = 0; pointer increments by 1 per read issued.
REQ-019 Fetch pointer SHALL wrap from 2^PC_WIDTH-1 to 0; a 32-bit instruction straddling the wrap takes its second word from address 0.
REQ-020 SHALL write imem_data into the FIFO on the edge ending the cycle after the matching imem_read, unless that read was cancelled by a branch.
REQ-021 fetchvalid SHALL be 1 when branch_valid = 0 and either head word bit 15 = 0 and occupancy >= 1, or head word bit 15 = 1 and occupancy >= 2.
REQ-022 An instruction SHALL transfer when fetchvalid = 1 and decode_stall = 0; the FIFO then pops 1 word (16-bit) or 2 words (32-bit).
REQ-023 While decode_stall = 1, fetchoutput, fetchlong, fetchpc and fetchillegal SHALL hold stable.
REQ-024 Push and pop in the same cycle SHALL both take effect; occupancy never exceeds BUFFER_DEPTH and never underflows.
REQ-025 When branch_valid = 1: FIFO emptied, all in-flight reads cancelled, pointer loaded with branch_target, no read issued that cycle; first read from branch_target issues the following cycle.
REQ-026 branch_valid SHALL take priority over any transfer, push or read in the same cycle.
REQ-027 Latency: a 16-bit instruction SHALL be presented with fetchvalid = 1 two cycles after its imem_read; a 32-bit instruction one cycle after its second word arrives.
REQ-028 Sustained throughput without stall or branch SHALL be one 16-bit instruction per cycle, or one 32-bit instruction per two cycles.
REQ-029 When fetchvalid = 0, fetchoutput, fetchlong and fetchillegal SHALL be 0.

Reset
REQ-030 While reset = 0 at an edge: pointer = RESET_PC, FIFO empty, in-flight reads cleared.
REQ-031 During and immediately after reset: imem_read = 0, fetchvalid = 0, fetchoutput = 0, fetchlong = 0, fetchillegal = 0, fetchpc = RESET_PC.
REQ-032 Reset asserted mid-operation SHALL discard buffered words and the in-flight response, with no further write into the FIFO.
REQ-033 First imem_read SHALL assert in the first cycle after reset deasserts.

Configuration
REQ-034 With macro AAP_FETCH_ILLEGAL_CHECK_EN defined: fetchillegal = 1 alongside fetchvalid when fetchlong = 1 and second word bit 15 = 0; the instruction still transfers as 32-bit.
REQ-035 Without AAP_FETCH_ILLEGAL_CHECK_EN: fetchillegal is tied to 0 and no check logic is built; all other behaviour is identical.

Verification
REQ-036 Reset release, memory words 0..3 = 16'h1234,16'h0001,16'h0002,16'h0003, no stall -> fetchvalid first high 2 cycles after first read, fetchoutput 32'h00001234 with fetchpc 0, then 0x0001 at fetchpc 1, one per cycle.
REQ-037 Words at 4,5 = 16'h8A01,16'h8002 -> fetchvalid one cycle after word 5 arrives, fetchoutput 32'h80028A01, fetchlong 1, fetchpc 4, FIFO pops 2.
REQ-038 decode_stall held 10 cycles -> outputs stable, occupancy saturates at 4, imem_read deasserts, no word lost or duplicated after release.
REQ-039 branch_valid with branch_target 16'h0040 while 2 words buffered and 1 in flight -> fetchvalid 0 that cycle and the next; next read at 16'h0040; stale words never presented.
REQ-040 RESET_PC = 16'hFFFF, word FFFF = 16'h8100, word 0000 = 16'h0005 -> fetchoutput 32'h00058100, fetchpc 16'hFFFF, fetchillegal 1 only with AAP_FETCH_ILLEGAL_CHECK_EN.
REQ-041 reset driven low while 3 words buffered -> next cycle fetchvalid 0, imem_read 0, fetchpc = RESET_PC.
